// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C read sequencer: master command codes and sequencer states.
package i2c_pkg;

  typedef enum logic [2:0] {
    OP_START     = 3'd0,
    OP_RSTART    = 3'd1,
    OP_WRITE     = 3'd2,
    OP_READ_ACK  = 3'd3,
    OP_READ_NACK = 3'd4,
    OP_STOP      = 3'd5
  } cmd_op_t;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_START    = 4'd1,
    ST_ADDR_W   = 4'd2,
    ST_REG_ADDR = 4'd3,
    ST_RSTART   = 4'd4,
    ST_ADDR_R   = 4'd5,
    ST_READ     = 4'd6,
    ST_STOP     = 4'd7,
    ST_ERR_STOP = 4'd8
  } seq_state_t;

  // Address byte on the bus: 7-bit device address followed by the R/W bit.
  function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rd);
    return {dev, rd};
  endfunction

endpackage

// File: rtl/poll_timer.sv
// Free-running poll interval timer: counts clk cycles while the sequencer is idle and
// polling is enabled, pulsing expire on the last cycle of each interval.
module poll_timer #(
  parameter int POLL_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic poll_en,
  input  logic idle,
  input  logic restart,
  output logic expire
);

  localparam int CNT_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(POLL_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign expire = poll_en && idle && (cnt == LAST);

  // Interval counter: held at zero when polling is off, reloads on expiry or when the
  // sequencer leaves idle, otherwise advances only during idle cycles.
  always_ff @(posedge clk) begin
    if (reset || !poll_en || restart || expire) begin
      cnt <= '0;
    end else if (idle) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_read_sequencer.sv
// Register-read sequencer driving a byte-level I2C master: START, address+W, register
// address, repeated START, address+R, N reads, STOP, with retry on NACKed writes.
module i2c_read_sequencer
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR       = 7'h68,
  parameter int         REG_ADDR_BYTES = 1,
  parameter int         READ_BYTES     = 2,
  parameter int         POLL_CYCLES    = 50_000_000,
  parameter int         MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        poll_en,
  input  logic [15:0] reg_addr,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_op,
  output logic [7:0]  cmd_data,
  input  logic        rsp_valid,
  input  logic        rsp_nack,
  input  logic [7:0]  rsp_data,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic [3:0]  byte_idx,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [3:0] LAST_IDX = 4'(READ_BYTES - 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
  localparam bit TWO_ADDR = (REG_ADDR_BYTES == 2);

  seq_state_t         state, state_nxt;
  logic               waiting, waiting_nxt;   // command accepted, response still pending
  logic               reg_sel, reg_sel_nxt;   // register-address byte in flight (0 = first)
  logic [RETRY_W-1:0] retry_cnt, retry_nxt;
  logic [15:0]        addr_lat, addr_lat_nxt;
  logic [3:0]         idx_nxt;
  logic               poll_expire;
  logic               start;
  logic               handshake;
  logic               rsp_take;

  assign busy      = (state != ST_IDLE);
  assign cmd_valid = busy && !waiting;
  assign handshake = cmd_valid && cmd_ready;
  assign rsp_take  = waiting && rsp_valid;
  // go and a poll expiry in the same cycle collapse into a single start.
  assign start     = (state == ST_IDLE) && (go || poll_expire);

  poll_timer #(
    .POLL_CYCLES(POLL_CYCLES)
  ) u_poll_timer (
    .clk    (clk),
    .reset  (reset),
    .poll_en(poll_en),
    .idle   (state == ST_IDLE),
    .restart(start),
    .expire (poll_expire)
  );

  // Control state: FSM, handshake phase, retry count and read index; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      waiting   <= 1'b0;
      reg_sel   <= 1'b0;
      retry_cnt <= '0;
      byte_idx  <= 4'd0;
    end else begin
      state     <= state_nxt;
      waiting   <= waiting_nxt;
      reg_sel   <= reg_sel_nxt;
      retry_cnt <= retry_nxt;
      byte_idx  <= idx_nxt;
    end
  end

  // Register address captured at transaction start; pure data, no reset needed.
  always_ff @(posedge clk) begin
    addr_lat <= addr_lat_nxt;
  end

  // Next-state and command/strobe decode; a state advances only on its own command's response.
  always_comb begin
    state_nxt    = state;
    waiting_nxt  = waiting;
    reg_sel_nxt  = reg_sel;
    retry_nxt    = retry_cnt;
    addr_lat_nxt = addr_lat;
    idx_nxt      = byte_idx;
    cmd_op       = OP_START;
    cmd_data     = 8'h00;
    byte_valid   = 1'b0;
    byte_data    = 8'h00;
    done         = 1'b0;
    error        = 1'b0;

    if (handshake) waiting_nxt = 1'b1;
    if (rsp_take)  waiting_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          addr_lat_nxt = reg_addr;
          idx_nxt      = 4'd0;
          reg_sel_nxt  = 1'b0;
          retry_nxt    = '0;
          state_nxt    = ST_START;
        end
      end
      ST_START: begin
        cmd_op = OP_START;
        if (rsp_take) state_nxt = ST_ADDR_W;
      end
      ST_ADDR_W: begin
        cmd_op   = OP_WRITE;
        cmd_data = addr_byte(DEV_ADDR, 1'b0);
        if (rsp_take) begin
          reg_sel_nxt = 1'b0;
          state_nxt   = rsp_nack ? ST_ERR_STOP : ST_REG_ADDR;
        end
      end
      ST_REG_ADDR: begin
        cmd_op   = OP_WRITE;
        cmd_data = (TWO_ADDR && !reg_sel) ? addr_lat[15:8] : addr_lat[7:0];
        if (rsp_take) begin
          if (rsp_nack)                  state_nxt   = ST_ERR_STOP;
          else if (TWO_ADDR && !reg_sel) reg_sel_nxt = 1'b1;
          else                           state_nxt   = ST_RSTART;
        end
      end
      ST_RSTART: begin
        cmd_op = OP_RSTART;
        if (rsp_take) state_nxt = ST_ADDR_R;
      end
      ST_ADDR_R: begin
        cmd_op   = OP_WRITE;
        cmd_data = addr_byte(DEV_ADDR, 1'b1);
        if (rsp_take) state_nxt = rsp_nack ? ST_ERR_STOP : ST_READ;
      end
      ST_READ: begin
        // The final byte is NACKed so the slave releases SDA before STOP.
        cmd_op = (byte_idx == LAST_IDX) ? OP_READ_NACK : OP_READ_ACK;
        if (rsp_take) begin
          byte_valid = 1'b1;
          byte_data  = rsp_data;
          idx_nxt    = byte_idx + 4'd1;
          if (byte_idx == LAST_IDX) state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        cmd_op = OP_STOP;
        if (rsp_take) begin
          done      = 1'b1;
          retry_nxt = '0;
          state_nxt = ST_IDLE;
        end
      end
      ST_ERR_STOP: begin
        cmd_op = OP_STOP;
        if (rsp_take) begin
          if (retry_cnt < RETRY_LIMIT) begin
            retry_nxt = retry_cnt + RETRY_W'(1);
            state_nxt = ST_START;
          end else begin
            error     = 1'b1;
            retry_nxt = '0;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: doc/i2c_read_sequencer.md
I2C_READ_SEQUENCER -- requirements
Module: i2c_read_sequencer

Interface
REQ-001 Parameter DEV_ADDR, 7'h68, 7-bit I2C slave address.
REQ-002 Parameter REG_ADDR_BYTES, 1, register-address length in bytes; legal values are 1 and 2.
REQ-003 Parameter READ_BYTES, 2, bytes read per transaction; legal range is 1..16.
REQ-004 Parameter POLL_CYCLES, 50_000_000, clk cycles between automatic transactions.
REQ-005 Parameter MAX_RETRY, 3, NACKed attempts allowed before error.
REQ-006 clk  in  1  single clock for all logic.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 go  in  1  single-cycle request for one transaction.
REQ-009 poll_en  in  1  enables automatic transactions every POLL_CYCLES.
REQ-010 reg_addr  in  16  register address, sampled at transaction start; low byte is used when REG_ADDR_BYTES=1.
REQ-011 cmd_valid / cmd_ready  out / in  1 / 1  command handshake to the byte-level i2c_master.
REQ-012 cmd_op  out  3  command code: START=0, RSTART=1, WRITE=2, READ_ACK=3, READ_NACK=4, STOP=5.
REQ-013 cmd_data  out  8  write byte for WRITE commands; 0 otherwise.
REQ-014 rsp_valid, rsp_nack, rsp_data  in  1, 1, 8  master completion strobe, NACK flag, and read byte.
REQ-015 byte_valid, byte_data, byte_idx  out  1, 8, 4  one-cycle delivery of each read byte and its index.
REQ-016 busy, done, error  out  1, 1, 1  transaction active; one-cycle success pulse; one-cycle failure pulse.

Function
REQ-017 FSM states: IDLE, START, ADDR_W, REG_ADDR, RSTART, ADDR_R, READ, STOP, ERR_STOP.
REQ-018 IDLE leaves on go, or on poll timer expiry while poll_en=1; it latches reg_addr, clears byte_idx, and enters START.
REQ-019 At most one command is outstanding at a time.
REQ-020 cmd_valid asserts on entry to each command state; cmd_op and cmd_data hold stable until the cycle with cmd_valid and cmd_ready both high.
REQ-021 After that handshake, the FSM waits for rsp_valid before it advances.
REQ-022 Command sequence: START, then WRITE {DEV_ADDR,0}, then WRITE of the register-address bytes (MSB first when 2 bytes), then RSTART, then WRITE {DEV_ADDR,1}, then READ_BYTES reads, then STOP.
REQ-023 Each read except the last uses READ_ACK; the last uses READ_NACK.
REQ-024 On each read rsp_valid, byte_valid pulses in the same cycle with byte_data=rsp_data and the current byte_idx; byte_idx then increments.
REQ-025 rsp_nack on any WRITE goes to ERR_STOP, which issues STOP and increments the retry count.
REQ-026 After ERR_STOP, if retries < MAX_RETRY the FSM re-enters START; otherwise it pulses error and returns to IDLE.
REQ-027 Completion of STOP on the success path pulses done, clears the retry count, and returns to IDLE.
REQ-028 rsp_nack on a read response is ignored.
REQ-029 The poll timer counts clk cycles only in IDLE with poll_en=1, reloads on expiry or on leaving IDLE, and is held at 0 when poll_en=0.
REQ-030 go or a poll expiry that arrives while busy=1 is dropped, not queued.
REQ-031 If go and poll expiry occur in the same cycle, exactly one transaction starts.
REQ-032 rsp_valid received while no command is outstanding is ignored.
REQ-033 busy=1 in every state except IDLE.

Reset
REQ-034 On reset: state=IDLE; cmd_valid=0; cmd_op=0; cmd_data=0; byte_valid=0; byte_data=0; byte_idx=0; busy=0; done=0; error=0; retry count=0; poll timer=0.
REQ-035 Reset during a transaction abandons it immediately, with no STOP issued.

Structure
REQ-036 The cmd_op encodings and the FSM state encoding shall live in the shared package i2c_pkg.
REQ-037 The poll timer shall be a separate sub-module, poll_timer, parameterised by POLL_CYCLES.

Verification
REQ-038 Defaults, go=1 with reg_addr=16'h003B, and the master model always ACKs -> commands in order START, WRITE 8'hD0, WRITE 8'h3B, RSTART, WRITE 8'hD1, READ_ACK, READ_NACK, STOP; byte_idx 0 then 1; one done pulse.
REQ-039 REG_ADDR_BYTES=2, reg_addr=16'h1234 -> WRITE 8'h12 then WRITE 8'h34 appear before RSTART.
REQ-040 Master model NACKs the address byte 4 times -> 4 START/STOP pairs, one error pulse, no done pulse.
REQ-041 Master model NACKs once then ACKs -> 2 START commands, then done; the retry count is back to 0.
REQ-042 POLL_CYCLES=100 with poll_en=1 -> transactions start 100 IDLE cycles apart; go pulsed while busy=1 starts no extra transaction.
REQ-043 reset asserted while in READ -> the next cycle shows the reset values of REQ-034 and no STOP command is issued.
